// File: rtl/reboot_pkg.sv
// Shared types and constants for the reboot controller: FSM encoding, software
// key values and helpers that locate the sw/wdt bits inside the reason vector.
package reboot_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StWarn,
    StAssert,
    StHoldoff
  } state_e;

  // Two-step software reboot keys
  localparam logic [15:0] KeyArm  = 16'hA55A;
  localparam logic [15:0] KeyFire = 16'h5AA5;

  // Quiet time after the reset pulse before new requests are accepted
  localparam int unsigned HoldoffCycles = 16;

  // Reason vector layout: [n_src-1:0] hw sources, then sw, then wdt
  function automatic int unsigned reason_sw_bit(input int unsigned n_src);
    return n_src;
  endfunction

  function automatic int unsigned reason_wdt_bit(input int unsigned n_src);
    return n_src + 1;
  endfunction

  // States in which new reboot causes are accepted
  function automatic logic state_is_quiet(input state_e s);
    return (s == StIdle) || (s == StArmed);
  endfunction

endpackage

// File: rtl/reboot_wdt.sv
// Watchdog down-counter. Counts while enabled and not held; a kick, a disable
// or an explicit reload restores the full timeout. Expire pulses when the count
// sits at zero during a counting cycle without a kick (kick wins the tie).
module reboot_wdt #(
  parameter int unsigned CYCLES = 50000000,
  parameter int unsigned CNT_W  = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic kick,
  input  logic hold,
  input  logic reload,
  output logic expire
);

  localparam logic [CNT_W-1:0] LoadVal = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count and expiry detection
  always_comb begin
    cnt_d  = cnt_q;
    expire = en && !hold && !kick && (cnt_q == '0);
    if (kick || !en || reload) begin
      cnt_d = LoadVal;
    end else if (!hold && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= LoadVal;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reboot_ctrl_multi.sv
// Reboot controller: merges masked hardware request edges, a keyed ARM/FIRE
// software reboot and a watchdog into a pre-warned, timed system reset pulse.
// Latches the one-hot reason and a saturating reboot count for telemetry.
module reboot_ctrl_multi
  import reboot_pkg::*;
#(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned WDT_CYCLES  = 50000000,
  parameter int unsigned WARN_CYCLES = 1000,
  parameter int unsigned HOLD_CYCLES = 256,
  parameter int unsigned ARM_WIN     = 4096,
  parameter int unsigned CNT_W       = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_req,
  input  logic [N_SRC-1:0] src_mask,
  input  logic             sw_key_wr,
  input  logic [15:0]      sw_key,
  input  logic             wdt_en,
  input  logic             wdt_kick,
  input  logic             reason_clr,
  output logic             sys_rst_n,
  output logic             pre_warn,
  output logic             busy,
  output logic [N_SRC+1:0] reason,
  output logic [7:0]       boot_cnt
);

  localparam int unsigned SwBit  = reason_sw_bit(N_SRC);
  localparam int unsigned WdtBit = reason_wdt_bit(N_SRC);

  localparam logic [CNT_W-1:0] ArmLoad     = CNT_W'(ARM_WIN - 1);
  localparam logic [CNT_W-1:0] WarnLoad    = CNT_W'(WARN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLoad    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldoffLoad = CNT_W'(HoldoffCycles - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_SRC-1:0] src_q;
  logic             primed_q;
  logic [N_SRC-1:0] hw_edge;
  logic [N_SRC-1:0] hw_first;

  logic             quiet;
  logic             key_arm;
  logic             key_fire;
  logic             sw_cause;
  logic             wdt_expire;
  logic             trigger;
  logic             warn_entry;
  logic             assert_entry;
  logic             leave_holdoff;
  logic [N_SRC+1:0] reason_next;

  logic [N_SRC+1:0] reason_q;
  logic [7:0]       boot_cnt_q;

  // Cause detection and the one-hot priority encode (wdt > sw > lowest hw)
  always_comb begin
    quiet    = state_is_quiet(state_q);
    key_arm  = sw_key_wr && (sw_key == KeyArm);
    key_fire = sw_key_wr && (sw_key == KeyFire);
    sw_cause = (state_q == StArmed) && key_fire;
    // The first sampled level after reset only primes the detector
    hw_edge  = primed_q ? (src_req & ~src_q & src_mask) : '0;
    // Isolate the lowest set bit
    hw_first = hw_edge & (-hw_edge);
    trigger  = quiet && (wdt_expire || sw_cause || (|hw_edge));

    reason_next = '0;
    if (wdt_expire) begin
      reason_next[WdtBit] = 1'b1;
    end else if (sw_cause) begin
      reason_next[SwBit] = 1'b1;
    end else begin
      reason_next[N_SRC-1:0] = hw_first;
    end

    warn_entry    = trigger;
    assert_entry  = (state_q == StWarn) && (cnt_q == '0);
    leave_holdoff = (state_q == StHoldoff) && (cnt_q == '0);
  end

  // FSM next state and shared down-counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d = StWarn;
          cnt_d   = WarnLoad;
        end else if (key_arm) begin
          state_d = StArmed;
          cnt_d   = ArmLoad;
        end
      end
      StArmed: begin
        if (trigger) begin
          state_d = StWarn;
          cnt_d   = WarnLoad;
        end else if (sw_key_wr || (cnt_q == '0)) begin
          // Wrong key or arm window expired: abandon without rebooting
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StWarn: begin
        if (cnt_q == '0) begin
          state_d = StAssert;
          cnt_d   = HoldLoad;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StAssert: begin
        if (cnt_q == '0) begin
          state_d = StHoldoff;
          cnt_d   = HoldoffLoad;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StHoldoff: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    sys_rst_n = (state_q != StAssert);
    pre_warn  = (state_q == StWarn);
    busy      = !quiet;
    reason    = reason_q;
    boot_cnt  = boot_cnt_q;
  end

  // Request edge detector; tracks src_req in every state so levels raised
  // during a reboot never look like fresh edges afterwards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      src_q    <= src_req;
      primed_q <= 1'b1;
    end
  end

  // Reason latch: a WARN-entry latch takes precedence over a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reason_q <= '0;
    end else if (warn_entry) begin
      reason_q <= reason_next;
    end else if (reason_clr) begin
      reason_q <= '0;
    end
  end

  // Saturating count of reset pulses issued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      boot_cnt_q <= '0;
    end else if (assert_entry && (boot_cnt_q != 8'hFF)) begin
      boot_cnt_q <= boot_cnt_q + 8'd1;
    end
  end

  reboot_wdt #(
    .CYCLES(WDT_CYCLES),
    .CNT_W (CNT_W)
  ) u_wdt (
    .clk   (clk),
    .rst   (rst),
    .en    (wdt_en),
    .kick  (wdt_kick),
    .hold  (!quiet),
    .reload(leave_holdoff),
    .expire(wdt_expire)
  );

endmodule

// File: tb/tb_reboot_ctrl_multi.sv
// Directed bench for reboot_ctrl_multi with short timing parameters.
module tb_reboot_ctrl_multi;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  src_req = '0;
  logic [3:0]  src_mask = 4'hF;
  logic        sw_key_wr = 1'b0;
  logic [15:0] sw_key = '0;
  logic        wdt_en = 1'b0;
  logic        wdt_kick = 1'b0;
  logic        reason_clr = 1'b0;
  logic        sys_rst_n;
  logic        pre_warn;
  logic        busy;
  logic [5:0]  reason;
  logic [7:0]  boot_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reboot_ctrl_multi #(
    .N_SRC      (N),
    .WDT_CYCLES (100),
    .WARN_CYCLES(10),
    .HOLD_CYCLES(20),
    .ARM_WIN    (50),
    .CNT_W      (26)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_req   (src_req),
    .src_mask  (src_mask),
    .sw_key_wr (sw_key_wr),
    .sw_key    (sw_key),
    .wdt_en    (wdt_en),
    .wdt_kick  (wdt_kick),
    .reason_clr(reason_clr),
    .sys_rst_n (sys_rst_n),
    .pre_warn  (pre_warn),
    .busy      (busy),
    .reason    (reason),
    .boot_cnt  (boot_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Latches the trigger set up by the caller, clears one-cycle strobes, then
  // follows the controller until it is no longer busy (bounded).
  task automatic measure(output int first_pw, output int wn, output int hn, output int total);
    wn = 0;
    hn = 0;
    tick();
    total = 1;
    first_pw = int'(pre_warn);
    sw_key_wr = 1'b0;
    wdt_kick = 1'b0;
    reason_clr = 1'b0;
    if (pre_warn) wn++;
    if (!sys_rst_n) hn++;
    while (busy && total < 200) begin
      tick();
      total++;
      if (pre_warn) wn++;
      if (!sys_rst_n) hn++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    src_req = 4'b1000;
    idle(3);
    n_tests++;
    if ({sys_rst_n, pre_warn, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 100", {sys_rst_n, pre_warn, busy});
    end
    n_tests++;
    if ({reason, boot_cnt} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_regs: reason %b boot_cnt %0d want 0/0", reason, boot_cnt);
    end
    rst = 1'b1;
    idle(5);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL level_at_reset: busy %b want 0", busy);
    end
  endtask

  task automatic test_hw_edge();
    int fp, wn, hn, tot;
    src_req = 4'b1100;
    reason_clr = 1'b1;
    measure(fp, wn, hn, tot);
    n_tests++;
    if (fp !== 1) begin
      n_fail++;
      $display("FAIL hw_latency: pre_warn %0d want 1", fp);
    end
    n_tests++;
    if (wn !== 10 || hn !== 20 || tot !== 47) begin
      n_fail++;
      $display("FAIL hw_timing: warn %0d hold %0d total %0d want 10 20 47", wn, hn, tot);
    end
    n_tests++;
    if (reason !== 6'b000100) begin
      n_fail++;
      $display("FAIL hw_reason: got %b want 000100", reason);
    end
    n_tests++;
    if (boot_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL hw_boot_cnt: got %0d want 1", boot_cnt);
    end
    src_req = 4'b0000;
    reason_clr = 1'b1;
    tick();
    reason_clr = 1'b0;
    n_tests++;
    if (reason !== 6'b000000) begin
      n_fail++;
      $display("FAIL reason_clr: got %b want 000000", reason);
    end
  endtask

  task automatic test_masked();
    int fp, wn, hn, tot;
    src_mask = 4'b1101;
    src_req = 4'b0010;
    measure(fp, wn, hn, tot);
    n_tests++;
    if (tot !== 1 || wn !== 0 || reason !== 6'b000000 || boot_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL masked: total %0d warn %0d reason %b boot %0d want 1 0 000000 1",
               tot, wn, reason, boot_cnt);
    end
    src_req = 4'b0000;
    src_mask = 4'hF;
    tick();
  endtask

  task automatic test_sw_fire();
    int fp, wn, hn, tot;
    sw_key_wr = 1'b1;
    sw_key = 16'hA55A;
    tick();
    sw_key_wr = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL armed_busy: got %b want 0", busy);
    end
    idle(29);
    sw_key_wr = 1'b1;
    sw_key = 16'h5AA5;
    measure(fp, wn, hn, tot);
    n_tests++;
    if (fp !== 1 || tot !== 47 || reason !== 6'b010000 || boot_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL sw_fire: pw %0d total %0d reason %b boot %0d want 1 47 010000 2",
               fp, tot, reason, boot_cnt);
    end
  endtask

  task automatic test_arm_abort();
    int fp, wn, hn, tot;
    sw_key_wr = 1'b1;
    sw_key = 16'hA55A;
    tick();
    sw_key_wr = 1'b0;
    idle(51);
    sw_key_wr = 1'b1;
    sw_key = 16'h5AA5;
    measure(fp, wn, hn, tot);
    n_tests++;
    if (tot !== 1 || reason !== 6'b010000 || boot_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL arm_timeout: total %0d reason %b boot %0d want 1 010000 2",
               tot, reason, boot_cnt);
    end
    sw_key_wr = 1'b1;
    sw_key = 16'hA55A;
    tick();
    sw_key = 16'h1234;
    tick();
    sw_key_wr = 1'b0;
    idle(2);
    sw_key_wr = 1'b1;
    sw_key = 16'h5AA5;
    measure(fp, wn, hn, tot);
    n_tests++;
    if (tot !== 1 || boot_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL wrong_key_abort: total %0d boot %0d want 1 2", tot, boot_cnt);
    end
  endtask

  task automatic test_wdt();
    int fp, wn, hn, tot;
    reason_clr = 1'b1;
    tick();
    reason_clr = 1'b0;
    wdt_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      wdt_kick = 1'b1;
      tick();
      wdt_kick = 1'b0;
      idle(89);
      n_tests++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL wdt_kicked_round%0d: busy %b want 0", r, busy);
      end
    end
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;
    idle(99);
    n_tests++;
    if (pre_warn !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wdt_early: pre_warn %b busy %b want 0 0", pre_warn, busy);
    end
    measure(fp, wn, hn, tot);
    wdt_en = 1'b0;
    n_tests++;
    if (fp !== 1 || tot !== 47 || reason !== 6'b100000 || boot_cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL wdt_expire: pw %0d total %0d reason %b boot %0d want 1 47 100000 3",
               fp, tot, reason, boot_cnt);
    end
    tick();
  endtask

  task automatic test_wdt_tie();
    int fp, wn, hn, tot;
    reason_clr = 1'b1;
    tick();
    reason_clr = 1'b0;
    wdt_en = 1'b1;
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;
    idle(99);
    // Count is zero now; a kick in this cycle must win
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL kick_tie: busy %b want 0", busy);
    end
    idle(99);
    src_req = 4'b0001;
    measure(fp, wn, hn, tot);
    wdt_en = 1'b0;
    n_tests++;
    if (fp !== 1 || reason !== 6'b100000 || boot_cnt !== 8'd4) begin
      n_fail++;
      $display("FAIL wdt_vs_hw: pw %0d reason %b boot %0d want 1 100000 4", fp, reason, boot_cnt);
    end
    src_req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_assert();
    src_req = 4'b0010;
    tick();
    idle(14);
    n_tests++;
    if (sys_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL in_assert: sys_rst_n %b want 0", sys_rst_n);
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({sys_rst_n, pre_warn, busy, reason, boot_cnt} !== {3'b100, 14'd0}) begin
      n_fail++;
      $display("FAIL async_reset: rst_n %b pw %b busy %b reason %b boot %0d want 1 0 0 0 0",
               sys_rst_n, pre_warn, busy, reason, boot_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    src_req = 4'b0000;
    idle(2);
    n_tests++;
    if (busy !== 1'b0 || boot_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL post_reset: busy %b boot %0d want 0 0", busy, boot_cnt);
    end
  endtask

  task automatic test_saturate();
    int fp, wn, hn, tot;
    for (int i = 0; i < 260; i++) begin
      src_req = 4'b0001;
      measure(fp, wn, hn, tot);
      src_req = 4'b0000;
      tick();
      if (i == 253) begin
        n_tests++;
        if (boot_cnt !== 8'hFE) begin
          n_fail++;
          $display("FAIL sat_254: got %0d want 254", boot_cnt);
        end
      end
    end
    n_tests++;
    if (boot_cnt !== 8'hFF) begin
      n_fail++;
      $display("FAIL sat_final: got %0d want 255", boot_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_hw_edge();
    test_masked();
    test_sw_fire();
    test_arm_abort();
    test_wdt();
    test_wdt_tie();
    test_reset_mid_assert();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
